rglib_rotate_arb: RTL

- Round-robin arbiter that shares one rglib_rotate datapath instance between REQ_NUM requesters.
- Accepts rotate requests (data + rotate amount) over valid/ready handshakes and issues at most one per cycle to the rotate unit.
- Tracks the requester ID of every in-flight operation in an in-order tag FIFO.
- Routes each rotate result back to the requester that issued it; sits directly in front of the rotate unit.

---
 rtl/rglib_rotate_arb.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rglib_rotate_arb.sv
// Round-robin front end for a shared rotate unit. Grants one requester per
// cycle, issues its operand to the rotate unit one cycle later, remembers the
// requester ID in an in-order tag FIFO and steers each returning result back
// to the requester that issued it.
module rglib_rotate_arb #(
  parameter int REQ_NUM          = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int ROTATE_STAGE_NUM = 1,
  parameter int TAG_DEPTH        = 4
) (
  input  logic                                  clk,
  input  logic                                  kill,
  input  logic [REQ_NUM-1:0]                    req_valid,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]         req_data,
  input  logic [REQ_NUM*ROTATE_STAGE_NUM-1:0]   req_rot,
  output logic [REQ_NUM-1:0]                    req_ready,
  output logic                                  rot_in_valid,
  output logic [DATA_WIDTH-1:0]                 rot_in,
  output logic [ROTATE_STAGE_NUM-1:0]           rot_val,
  input  logic                                  rot_out_valid,
  input  logic [DATA_WIDTH-1:0]                 rot_out,
  output logic [REQ_NUM-1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]                 rsp_data,
  output logic [$clog2(TAG_DEPTH+1)-1:0]        occupancy,
  output logic                                  err_underflow
);

  localparam int IDXW = $clog2(REQ_NUM);
  localparam int PTRW = $clog2(TAG_DEPTH);
  localparam int OCCW = $clog2(TAG_DEPTH+1);

  logic [IDXW-1:0]             last_grant_q, last_grant_d;
  logic                        rot_in_valid_q, rot_in_valid_d;
  logic [DATA_WIDTH-1:0]       rot_in_q, rot_in_d;
  logic [ROTATE_STAGE_NUM-1:0] rot_val_q, rot_val_d;
  logic [IDXW-1:0]             tag_mem_q [TAG_DEPTH];
  logic [IDXW-1:0]             tag_mem_d [TAG_DEPTH];
  logic [PTRW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [OCCW-1:0]             occupancy_q, occupancy_d;
  logic [REQ_NUM-1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic                        err_q, err_d;

  logic                        grant_found;
  logic [IDXW-1:0]             grant_idx;
  logic [IDXW-1:0]             cand;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;
  logic [IDXW-1:0]             head_id;

  assign fifo_full  = (occupancy_q == OCCW'(TAG_DEPTH));
  assign fifo_empty = (occupancy_q == '0);
  assign push       = grant_found;
  assign pop        = rot_out_valid && !fifo_empty;
  assign head_id    = tag_mem_q[rd_ptr_q];

  // Rotating priority search starting just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    req_ready   = '0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      cand = IDXW'((int'(last_grant_q) + k) % REQ_NUM);
      if (!grant_found && !fifo_full && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Capture the granted operand for the rotate unit; hold it otherwise.
  always_comb begin
    last_grant_d   = grant_found ? grant_idx : last_grant_q;
    rot_in_valid_d = push;
    rot_in_d       = rot_in_q;
    rot_val_d      = rot_val_q;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (req_ready[i]) begin
        rot_in_d  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        rot_val_d = req_rot[i*ROTATE_STAGE_NUM +: ROTATE_STAGE_NUM];
      end
    end
  end

  // Tag FIFO bookkeeping; full/empty come from occupancy, pointers just wrap.
  always_comb begin
    tag_mem_d = tag_mem_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = grant_idx;
    end
    wr_ptr_d = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   occupancy_d = occupancy_q + OCCW'(1);
      2'b01:   occupancy_d = occupancy_q - OCCW'(1);
      default: occupancy_d = occupancy_q;
    endcase
  end

  // Steer a returning result to the requester at the FIFO head; flag orphans.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pop) begin
      rsp_data_d = rot_out;
      for (int i = 0; i < REQ_NUM; i++) begin
        if (head_id == IDXW'(i)) begin
          rsp_valid_d[i] = 1'b1;
        end
      end
    end
    err_d = err_q | (rot_out_valid && fifo_empty);
  end

  // State registers; kill discards everything including in-flight tags.
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      last_grant_q   <= IDXW'(REQ_NUM - 1);
      rot_in_valid_q <= 1'b0;
      rot_in_q       <= '0;
      rot_val_q      <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      occupancy_q    <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      last_grant_q   <= last_grant_d;
      rot_in_valid_q <= rot_in_valid_d;
      rot_in_q       <= rot_in_d;
      rot_val_q      <= rot_val_d;
      tag_mem_q      <= tag_mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      occupancy_q    <= occupancy_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      err_q          <= err_d;
    end
  end

  assign rot_in_valid  = rot_in_valid_q;
  assign rot_in        = rot_in_q;
  assign rot_val       = rot_val_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign occupancy     = occupancy_q;
  assign err_underflow = err_q;

endmodule
